// File: rtl/seq_signed_mult_pkg.sv
// Shared types and helpers for the sequential signed multiplier.
package seq_signed_mult_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // 0x80000000 maps to itself, read back as the unsigned magnitude 2^31.
  function automatic logic [WIDTH-1:0] abs32(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [PROD_W-1:0] neg64(input logic [PROD_W-1:0] x);
    return ~x + 1'b1;
  endfunction

endpackage

// File: rtl/mult_shift_add_core.sv
// Radix-2 shift-add datapath over unsigned operand magnitudes.
module mult_shift_add_core #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned VARIABLE_LATENCY = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     mlier_mag_i,
  input  logic [WIDTH-1:0]     mcand_mag_i,
  output logic [2*WIDTH-1:0]   acc_next_o,
  output logic                 last_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [WIDTH-1:0]   mlier_q, mlier_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  always_comb begin
    acc_next_o = mlier_q[0] ? (acc_q + mcand_q) : acc_q;
    // Early exit once this iteration consumes the last set multiplier bit.
    last_o = (cnt_q == LastCnt) ||
             ((VARIABLE_LATENCY != 0) && (mlier_q[WIDTH-1:1] == '0));
  end

  always_comb begin
    mlier_d = mlier_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      mlier_d = mlier_mag_i;
      mcand_d = {{WIDTH{1'b0}}, mcand_mag_i};
      acc_d   = '0;
      cnt_d   = '0;
    end else if (step_i) begin
      mlier_d = mlier_q >> 1;
      mcand_d = mcand_q << 1;
      acc_d   = acc_next_o;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mlier_q <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      mlier_q <= mlier_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_signed_mult.sv
// Sequential signed multiplier: start edge detect, sign fix-up, control FSM.
module seq_signed_mult #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned VARIABLE_LATENCY = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     mlier,
  input  logic [WIDTH-1:0]     mcand,
  output logic [2*WIDTH-1:0]   prodt,
  input  logic                 start,
  output logic                 valid
);
  import seq_signed_mult_pkg::*;

  state_e             state_q, state_d;
  logic               start_prev_q;
  logic               sign_q, sign_d;
  logic [2*WIDTH-1:0] prodt_q, prodt_d;
  logic               valid_q, valid_d;

  logic               capture;
  logic               busy;
  logic [2*WIDTH-1:0] acc_next;
  logic               last;

  assign capture = start && !start_prev_q && (state_q == IDLE);
  assign busy    = (state_q == BUSY);

  mult_shift_add_core #(
    .WIDTH           (WIDTH),
    .VARIABLE_LATENCY(VARIABLE_LATENCY)
  ) u_core (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (capture),
    .step_i     (busy),
    .mlier_mag_i(abs32(mlier)),
    .mcand_mag_i(abs32(mcand)),
    .acc_next_o (acc_next),
    .last_o     (last)
  );

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    prodt_d = prodt_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          sign_d  = mlier[WIDTH-1] ^ mcand[WIDTH-1];
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (last) begin
          // A zero magnitude stays zero regardless of the operand signs.
          prodt_d = (sign_q && (acc_next != '0)) ? neg64(acc_next) : acc_next;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      sign_q       <= 1'b0;
      prodt_q      <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start;
      sign_q       <= sign_d;
      prodt_q      <= prodt_d;
      valid_q      <= valid_d;
    end
  end

  assign prodt = prodt_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_seq_signed_mult.sv
// Scoreboard bench driving fixed- and variable-latency instances side by side.
module tb_seq_signed_mult;

  typedef struct {
    logic [63:0] prod;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mlier = '0;
  logic [31:0] mcand = '0;
  logic        start = 1'b0;
  logic [63:0] prodt_fix, prodt_var;
  logic        valid_fix, valid_var;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   cap_cyc  = 0;
  int   n_ops    = 0;
  int   nv_fix   = 0;
  int   nv_var   = 0;
  logic pv_fix   = 1'b0;
  logic pv_var   = 1'b0;
  exp_t q_fix[$];
  exp_t q_var[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_signed_mult #(.WIDTH(32), .VARIABLE_LATENCY(0)) u_fix (
    .clock(clk), .reset(rst), .mlier(mlier), .mcand(mcand),
    .prodt(prodt_fix), .start(start), .valid(valid_fix)
  );

  seq_signed_mult #(.WIDTH(32), .VARIABLE_LATENCY(1)) u_var (
    .clock(clk), .reset(rst), .mlier(mlier), .mcand(mcand),
    .prodt(prodt_var), .start(start), .valid(valid_var)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h, want 0x%016h", tag, obs, exp);
  endtask

  function automatic int lat_var(input logic [31:0] a);
    longint v;
    int     n;
    v = longint'($signed(a));
    if (v < 0) v = -v;
    n = 0;
    while (v != 0) begin
      n++;
      v = v >> 1;
    end
    return (n == 0) ? 1 : n;
  endfunction

  always @(negedge clk) begin
    if (valid_fix) begin
      exp_t e;
      nv_fix++;
      check_eq("fix_no_double_valid", 64'(pv_fix), 64'd0);
      if (q_fix.size() == 0) begin
        check_eq("fix_unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = q_fix.pop_front();
        check_eq("fix_prodt", prodt_fix, e.prod);
        check_eq("fix_latency", 64'(cyc - cap_cyc), 64'(e.lat));
      end
    end
    if (valid_var) begin
      exp_t e;
      nv_var++;
      check_eq("var_no_double_valid", 64'(pv_var), 64'd0);
      if (q_var.size() == 0) begin
        check_eq("var_unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = q_var.pop_front();
        check_eq("var_prodt", prodt_var, e.prod);
        check_eq("var_latency", 64'(cyc - cap_cyc), 64'(e.lat));
      end
    end
    pv_fix = valid_fix;
    pv_var = valid_var;
  end

  // hold: keep start high long after completion; abort: reset mid-operation.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input bit abort);
    exp_t ef, ev;
    ef.prod = 64'(longint'($signed(a)) * longint'($signed(b)));
    ef.lat  = 32;
    ev.prod = ef.prod;
    ev.lat  = lat_var(a);
    @(posedge clk);
    #1;
    mlier = a;
    mcand = b;
    start = 1'b1;
    cap_cyc = cyc + 1;
    q_fix.push_back(ef);
    q_var.push_back(ev);
    @(posedge clk);
    #1;
    mlier = $urandom;
    mcand = $urandom;
    if (abort) begin
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      start = 1'b0;
      q_fix.delete();
      q_var.delete();
      #1;
      check_eq("abort_prodt_fix", prodt_fix, 64'd0);
      check_eq("abort_prodt_var", prodt_var, 64'd0);
      check_eq("abort_valid", 64'({valid_fix, valid_var}), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check_eq("after_abort_prodt_fix", prodt_fix, 64'd0);
      check_eq("after_abort_prodt_var", prodt_var, 64'd0);
    end else begin
      for (int i = 0; i < 40 && (q_fix.size() != 0 || q_var.size() != 0); i++) begin
        @(posedge clk);
      end
      #1;
      check_eq("done_in_time", 64'(q_fix.size() + q_var.size()), 64'd0);
      q_fix.delete();
      q_var.delete();
      n_ops++;
      if (hold) repeat (40) @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check_eq("hold_prodt_fix", prodt_fix, ef.prod);
      check_eq("hold_prodt_var", prodt_var, ev.prod);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_prodt_fix", prodt_fix, 64'd0);
    check_eq("reset_prodt_var", prodt_var, 64'd0);
    check_eq("reset_valid_fix", 64'(valid_fix), 64'd0);
    check_eq("reset_valid_var", 64'(valid_var), 64'd0);
    rst = 1'b0;

    run_op(32'h0000_0001, 32'h7fff_ffff, 1'b0, 1'b0);
    run_op(32'h7fff_ffff, 32'h7fff_ffff, 1'b0, 1'b0);
    run_op(32'h7fff_ffff, 32'h8000_0000, 1'b0, 1'b0);
    run_op(32'hffff_ffff, 32'hffff_ffff, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op(32'hffff_fffd, 32'h0000_0005, 1'b0, 1'b0);
    run_op(32'h0000_0003, 32'hffff_fffb, 1'b1, 1'b0);
    run_op(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (k % 4 == 1) ra = ra >> $urandom_range(31, 0);
      if (k % 4 == 2) ra = -(ra >> $urandom_range(31, 0));
      run_op(ra, rb, 1'b0, 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    check_eq("valid_count_fix", 64'(nv_fix), 64'(n_ops));
    check_eq("valid_count_var", 64'(nv_var), 64'(n_ops));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
